// File: rtl/regfile_wb_sink_pkg.sv
// Shared definitions for the writeback-side architectural register file:
// default geometry, the register reset value and the register index type.
package regfile_wb_sink_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_REGS   = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    localparam logic [15:0] RESET_VALUE = 16'h0000;

    typedef logic [DEF_ADDR_WIDTH-1:0] regIdx_t;

endpackage

// File: rtl/regfile_wb_sink_cell_en.sv
// One architectural register with write enable and asynchronous active-low
// clear, plus the flag recording whether it was written since reset.
module regfile_cell_en
    import regfile_wb_sink_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  written
);

    // Commit the full-width write and mark the register as initialised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= DATA_WIDTH'(RESET_VALUE);
            written <= 1'b0;
        end else if (wrEn) begin
            q       <= wrData;
            written <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_sink.sv
// Architectural register file at the receiving end of writeback.
// One write port committed on the rising clock edge, two combinational read
// ports with per-port "never written since reset" indication, and a sticky
// err flag for writes to an index beyond NUM_REGS.
// Build option: define REGFILE_WB_BYPASS_EN to forward a same-cycle write to
// the read ports (write-before-read).
module regfile_wb_sink
    import regfile_wb_sink_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  WriteEn_In,
    input  logic [ADDR_WIDTH-1:0] WR_In,
    input  logic [DATA_WIDTH-1:0] WD_In,
    input  logic [ADDR_WIDTH-1:0] RR1_In,
    input  logic [ADDR_WIDTH-1:0] RR2_In,
    output logic [DATA_WIDTH-1:0] RD1_Out,
    output logic [DATA_WIDTH-1:0] RD2_Out,
    output logic                  Uninit1_Out,
    output logic                  Uninit2_Out,
    output logic                  err
);

    // armed is low from reset until the first clock edge after release, so a
    // write presented on the release edge is dropped rather than racing it.
    logic                  armed;
    logic                  commitEn;
    logic                  idxLegal;
    logic [NUM_REGS-1:0]   wrHit;
    logic [NUM_REGS-1:0]   cellWrEn;
    logic [NUM_REGS-1:0]   written;
    logic [DATA_WIDTH-1:0] regQ [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd1Stored;
    logic [DATA_WIDTH-1:0] rd2Stored;
    logic                  uninit1Stored;
    logic                  uninit2Stored;

    // Open the write path on the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // One-hot write decode; an index with no hit lies beyond NUM_REGS.
    always_comb begin
        wrHit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wrHit[i] = (WR_In == ADDR_WIDTH'(i));
        end
    end

    assign idxLegal = |wrHit;
    assign commitEn = WriteEn_In & armed;
    assign cellWrEn = wrHit & {NUM_REGS{commitEn}};

    // Sticky illegal-index flag; the write itself is discarded by the decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (commitEn && !idxLegal) begin
            err <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : gCell
        regfile_cell_en #(
            .DATA_WIDTH (DATA_WIDTH)
        ) uCell (
            .clk     (clk),
            .rst_n   (rst_n),
            .wrEn    (cellWrEn[g]),
            .wrData  (WD_In),
            .q       (regQ[g]),
            .written (written[g])
        );
    end

    // Read muxes over stored state; out-of-range indices read as unwritten 0.
    always_comb begin
        rd1Stored     = DATA_WIDTH'(RESET_VALUE);
        rd2Stored     = DATA_WIDTH'(RESET_VALUE);
        uninit1Stored = 1'b1;
        uninit2Stored = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (RR1_In == ADDR_WIDTH'(i)) begin
                rd1Stored     = regQ[i];
                uninit1Stored = ~written[i];
            end
            if (RR2_In == ADDR_WIDTH'(i)) begin
                rd2Stored     = regQ[i];
                uninit2Stored = ~written[i];
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    logic bypass1;
    logic bypass2;

    // Forward only writes that will actually commit (armed, legal index).
    always_comb begin
        bypass1 = commitEn & idxLegal & (RR1_In == WR_In);
        bypass2 = commitEn & idxLegal & (RR2_In == WR_In);
    end

    assign RD1_Out     = bypass1 ? WD_In : rd1Stored;
    assign RD2_Out     = bypass2 ? WD_In : rd2Stored;
    assign Uninit1_Out = bypass1 ? 1'b0  : uninit1Stored;
    assign Uninit2_Out = bypass2 ? 1'b0  : uninit2Stored;
`else
    assign RD1_Out     = rd1Stored;
    assign RD2_Out     = rd2Stored;
    assign Uninit1_Out = uninit1Stored;
    assign Uninit2_Out = uninit2Stored;
`endif

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed bench for regfile_wb_sink: default 8-register instance plus a
// 6-register instance for the illegal-index err path. Expected read results
// are queued when stimulus is applied and popped when the outputs are sampled.
module tb_regfile_wb_sink;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        WriteEn_In;
    logic [2:0]  WR_In;
    logic [15:0] WD_In;
    logic [2:0]  RR1_In;
    logic [2:0]  RR2_In;
    logic [15:0] RD1_Out;
    logic [15:0] RD2_Out;
    logic        Uninit1_Out;
    logic        Uninit2_Out;
    logic        err;

    logic        rst6n;
    logic        we6;
    logic [2:0]  wr6;
    logic [15:0] wd6;
    logic [2:0]  rr1b;
    logic [2:0]  rr2b;
    logic [15:0] rd1b;
    logic [15:0] rd2b;
    logic        u1b;
    logic        u2b;
    logic        err6;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        int          which;
        logic [15:0] rd1;
        logic        u1;
        logic [15:0] rd2;
        logic        u2;
        logic        err;
    } exp_t;

    exp_t sb[$];

    regfile_wb_sink #(.DATA_WIDTH(16), .NUM_REGS(8), .ADDR_WIDTH(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .WriteEn_In  (WriteEn_In),
        .WR_In       (WR_In),
        .WD_In       (WD_In),
        .RR1_In      (RR1_In),
        .RR2_In      (RR2_In),
        .RD1_Out     (RD1_Out),
        .RD2_Out     (RD2_Out),
        .Uninit1_Out (Uninit1_Out),
        .Uninit2_Out (Uninit2_Out),
        .err         (err)
    );

    regfile_wb_sink #(.DATA_WIDTH(16), .NUM_REGS(6), .ADDR_WIDTH(3)) dut6 (
        .clk         (clk),
        .rst_n       (rst6n),
        .WriteEn_In  (we6),
        .WR_In       (wr6),
        .WD_In       (wd6),
        .RR1_In      (rr1b),
        .RR2_In      (rr2b),
        .RD1_Out     (rd1b),
        .RD2_Out     (rd2b),
        .Uninit1_Out (u1b),
        .Uninit2_Out (u2b),
        .err         (err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic expectNow(input string tag, input int which,
                             input logic [15:0] e1, input logic eu1,
                             input logic [15:0] e2, input logic eu2,
                             input logic ee);
        exp_t e;
        e.tag = tag; e.which = which;
        e.rd1 = e1; e.u1 = eu1; e.rd2 = e2; e.u2 = eu2; e.err = ee;
        sb.push_back(e);
    endtask

    task automatic checkOut();
        exp_t e;
        logic [15:0] o1, o2;
        logic ou1, ou2, oe;
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            if (e.which == 0) begin
                o1 = RD1_Out; o2 = RD2_Out; ou1 = Uninit1_Out; ou2 = Uninit2_Out; oe = err;
            end else begin
                o1 = rd1b; o2 = rd2b; ou1 = u1b; ou2 = u2b; oe = err6;
            end
            cmp({e.tag, "_rd1"}, o1, e.rd1);
            cmp({e.tag, "_u1"}, 16'(ou1), 16'(e.u1));
            cmp({e.tag, "_rd2"}, o2, e.rd2);
            cmp({e.tag, "_u2"}, 16'(ou2), 16'(e.u2));
            cmp({e.tag, "_err"}, 16'(oe), 16'(e.err));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; WriteEn_In = 1'b0; WR_In = '0; WD_In = '0; RR1_In = '0; RR2_In = '0;
        rst6n = 1'b0; we6 = 1'b0; wr6 = '0; wd6 = '0; rr1b = '0; rr2b = '0;
        #2;

        // Reset state on every register, both ports.
        for (int i = 0; i < 8; i++) begin
            RR1_In = 3'(i);
            RR2_In = 3'(7 - i);
            expectNow($sformatf("rst_r%0d", i), 0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
            checkOut();
        end

        // A write held through reset must neither forward nor commit.
        WriteEn_In = 1'b1; WR_In = 3'd4; WD_In = 16'h4444; RR1_In = 3'd4; RR2_In = 3'd4;
        expectNow("rst_wr", 0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        checkOut();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        WriteEn_In = 1'b0; RR1_In = 3'd4; RR2_In = 3'd1;
        expectNow("rel_drop", 0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        checkOut();

        // Plain write, read next cycle.
        WriteEn_In = 1'b1; WR_In = 3'd3; WD_In = 16'hBEEF; RR1_In = 3'd2; RR2_In = 3'd2;
        tick();
        WriteEn_In = 1'b0; RR1_In = 3'd3; RR2_In = 3'd3;
        expectNow("r3", 0, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        checkOut();
        RR1_In = 3'd2;
        expectNow("r2_r3", 0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        checkOut();

        // Same-cycle write/read of R5.
        WriteEn_In = 1'b1; WR_In = 3'd5; WD_In = 16'h1234; RR1_In = 3'd5; RR2_In = 3'd3;
        expectNow("r5_same", 0, BYP ? 16'h1234 : 16'h0000, ~BYP, 16'hBEEF, 1'b0, 1'b0);
        checkOut();
        tick();
        WriteEn_In = 1'b0; RR1_In = 3'd5; RR2_In = 3'd5;
        expectNow("r5_next", 0, 16'h1234, 1'b0, 16'h1234, 1'b0, 1'b0);
        checkOut();

        // Back-to-back writes to R7, then a disabled write.
        WriteEn_In = 1'b1; WR_In = 3'd7; WD_In = 16'hAAAA;
        tick();
        WD_In = 16'h5555;
        tick();
        WriteEn_In = 1'b0; WD_In = 16'hFFFF; RR1_In = 3'd7; RR2_In = 3'd7;
        expectNow("r7_last", 0, 16'h5555, 1'b0, 16'h5555, 1'b0, 1'b0);
        checkOut();
        tick();
        expectNow("r7_noen", 0, 16'h5555, 1'b0, 16'h5555, 1'b0, 1'b0);
        checkOut();

        // Reset asserted between edges clears outputs immediately.
        RR1_In = 3'd3; RR2_In = 3'd5;
        expectNow("pre_rst", 0, 16'hBEEF, 1'b0, 16'h1234, 1'b0, 1'b0);
        checkOut();
        rst_n = 1'b0;
        expectNow("mid_rst", 0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        checkOut();
        WriteEn_In = 1'b1; WR_In = 3'd4; WD_In = 16'h4444; RR1_In = 3'd4; RR2_In = 3'd7;
        expectNow("mid_rst_wr", 0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        checkOut();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        WriteEn_In = 1'b0;
        expectNow("rel_drop2", 0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        checkOut();
        WriteEn_In = 1'b1;
        tick();
        WriteEn_In = 1'b0;
        expectNow("r4_after", 0, 16'h4444, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkOut();

        // Six-register instance: illegal index sets sticky err.
        @(negedge clk);
        rst6n = 1'b1;
        tick();
        rr1b = 3'd0; rr2b = 3'd5;
        expectNow("n6_init", 1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        checkOut();
        we6 = 1'b1; wr6 = 3'd6; wd6 = 16'h6666; rr1b = 3'd6; rr2b = 3'd5;
        expectNow("n6_ill_same", 1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        checkOut();
        tick();
        we6 = 1'b0;
        expectNow("n6_err", 1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);
        checkOut();
        for (int i = 0; i < 6; i++) begin
            rr1b = 3'(i);
            rr2b = 3'(5 - i);
            expectNow($sformatf("n6_r%0d", i), 1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);
            checkOut();
        end
        we6 = 1'b1; wr6 = 3'd2; wd6 = 16'h2222;
        tick();
        we6 = 1'b0; rr1b = 3'd2; rr2b = 3'd0;
        expectNow("n6_sticky", 1, 16'h2222, 1'b0, 16'h0000, 1'b1, 1'b1);
        checkOut();
        rst6n = 1'b0;
        expectNow("n6_rst", 1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        checkOut();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
